// File: rtl/imul_mul_rr_arbiter_if.sv
// Request, response and multiplier-side signals of the shared multiplier arbiter.
// Operand buses carry one NBITS slice per requester, requester i at [i*NBITS +: NBITS].
interface imul_mul_rr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int NBITS = 32
);
   logic [NREQ-1:0]       req_val;
   logic [NREQ-1:0]       req_rdy;
   logic [NREQ*NBITS-1:0] req_a;
   logic [NREQ*NBITS-1:0] req_b;
   logic [NREQ-1:0]       resp_val;
   logic [NREQ-1:0]       resp_rdy;
   logic [NBITS-1:0]      resp_msg;
   logic [NBITS-1:0]      mul_in0;
   logic [NBITS-1:0]      mul_in1;
   logic [NBITS-1:0]      mul_out;

   modport slave (
      input  req_val, req_a, req_b, resp_rdy, mul_out,
      output req_rdy, resp_val, resp_msg, mul_in0, mul_in1
   );

   modport master (
      output req_val, req_a, req_b, resp_rdy, mul_out,
      input  req_rdy, resp_val, resp_msg, mul_in0, mul_in1
   );
endinterface

// File: rtl/imul_mul_rr_arbiter.sv
// Round-robin share of one registered multiplier; request fire at t gives resp_val at t+2.
// A held response blocks new grants; a grant in RESP needs the owner's response to fire.
module imul_mul_rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int NBITS = 32
) (
   input  logic                clk,
   input  logic                reset,
   imul_mul_rr_arbiter_if.slave bus
);
   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    owner_q, owner_d;
   logic [NBITS-1:0] result_q, result_d;

   logic [PW-1:0]    win;
   logic [PW-1:0]    cand;
   logic             found;
   logic             grant;
   int               idx;

   logic [NREQ-1:0]  req_rdy;
   logic [NREQ-1:0]  resp_val;
   logic [NBITS-1:0] resp_msg;
   logic [NBITS-1:0] in0;
   logic [NBITS-1:0] in1;

   // First valid requester scanning upward from ptr, wrapping at NREQ.
   always_comb begin
      win   = ptr_q;
      found = 1'b0;
      idx   = 0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         cand = PW'(idx);
         if (!found && bus.req_val[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      result_d = result_q;
      grant    = 1'b0;
      req_rdy  = '0;
      resp_val = '0;
      resp_msg = '0;
      in0      = '0;
      in1      = '0;

      case (state_q)
         IDLE: begin
            grant = found;
         end
         CALC: begin
            result_d = bus.mul_out;
            state_d  = RESP;
         end
         RESP: begin
            resp_val[owner_q] = 1'b1;
            resp_msg          = result_q;
            if (bus.resp_rdy[owner_q]) begin
               grant   = found;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (grant) begin
         req_rdy[win] = 1'b1;
         in0          = bus.req_a[win*NBITS +: NBITS];
         in1          = bus.req_b[win*NBITS +: NBITS];
         owner_d      = win;
         ptr_d        = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
         state_d      = CALC;
      end

      // Outputs are forced quiet for the whole time reset is held low.
      if (!reset) begin
         req_rdy  = '0;
         resp_val = '0;
         resp_msg = '0;
         in0      = '0;
         in1      = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         result_q <= result_d;
      end
   end

   assign bus.req_rdy  = req_rdy;
   assign bus.resp_val = resp_val;
   assign bus.resp_msg = resp_msg;
   assign bus.mul_in0  = in0;
   assign bus.mul_in1  = in1;
endmodule
